// File: rtl/spi_arb_pkg.sv
// Shared types and default constants for the SPI transfer arbiter.
//   state_e : arbiter FSM states
//   rsp_t   : registered response (requester id, received byte, timeout flag)
package spi_arb_pkg;

  localparam int NUM_REQ_DEF   = 4;
  localparam int ID_W_DEF      = 2;
  localparam int SETUP_CYC_DEF = 4;
  localparam int CAP_DLY_DEF   = 2;
  localparam int GAP_CYC_DEF   = 8;
  localparam int TIMEOUT_DEF   = 256;

  // Wide enough for any supported ID_W; the top truncates to ID_W.
  localparam int RSP_ID_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_CAPTURE,
    ST_RESP,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic [RSP_ID_W-1:0] id;
    logic [7:0]          data;
    logic                err;
  } rsp_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick.
//   req     : request vector
//   ptr     : highest-priority index for this pick
//   gnt     : one-hot grant (first set bit at or above ptr, with wrap)
//   gnt_idx : index of the granted bit
//   gnt_any : at least one request present
module spi_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               gnt_any
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    // Outer loop walks priority order; inner loop maps the rotated slot
    // back to a constant bit position.
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!gnt_any && (j == ((int'(ptr) + i) % NUM_REQ)) && req[j]) begin
          gnt[j]  = 1'b1;
          gnt_idx = ID_W'(j);
          gnt_any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Round-robin sharing of one SPI byte master among NUM_REQ requesters.
//   clk, arst          : clock, synchronous active-high reset
//   req_*              : per-requester valid/data/mode, req_ready one-hot accept
//   rsp_*              : response (id, byte, timeout error) with valid/ready
//   m_*                : SPI master start/mode/data and completion flags
//   busy, grant_id     : FSM not idle, current/last granted requester
module spi_xfer_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int ID_W      = ID_W_DEF,
  parameter int SETUP_CYC = SETUP_CYC_DEF,
  parameter int CAP_DLY   = CAP_DLY_DEF,
  parameter int GAP_CYC   = GAP_CYC_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_cpol,
  input  logic [NUM_REQ-1:0]   req_cpha,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_data,
  output logic                 rsp_err,
  output logic                 m_start,
  output logic                 m_cpol,
  output logic                 m_cpha,
  output logic [7:0]           m_data_in,
  input  logic [7:0]           m_data_o,
  input  logic                 m_tx_done,
  input  logic                 m_rx_done,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id
);

  localparam int CNT_MAX = max_of(max_of(SETUP_CYC, CAP_DLY), max_of(GAP_CYC, TIMEOUT));
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [7:0]         m_data_in_q, m_data_in_d;
  logic               m_cpol_q, m_cpol_d;
  logic               m_cpha_q, m_cpha_d;
  logic               tx_prev_q, tx_prev_d, rx_prev_q, rx_prev_d;
  logic               tx_seen_q, tx_seen_d, rx_seen_q, rx_seen_d;
  rsp_t               rsp_q, rsp_d;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;

  spi_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // One shared counter serves every timed state; it saturates at all-ones.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_inc;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    m_data_in_d = m_data_in_q;
    m_cpol_d    = m_cpol_q;
    m_cpha_d    = m_cpha_q;
    tx_prev_d   = m_tx_done;
    rx_prev_d   = m_rx_done;
    tx_seen_d   = tx_seen_q;
    rx_seen_d   = rx_seen_q;
    rsp_d       = rsp_q;
    req_ready   = '0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (gnt_any) begin
          req_ready  = gnt;
          grant_id_d = gnt_idx;
          rr_ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
              m_data_in_d = req_data[8*i +: 8];
              m_cpol_d    = req_cpol[i];
              m_cpha_d    = req_cpha[i];
            end
          end
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        tx_seen_d = 1'b0;
        rx_seen_d = 1'b0;
        if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        // Rising edges only; a flag left high from a previous byte is ignored.
        tx_seen_d = tx_seen_q | (m_tx_done & ~tx_prev_q);
        rx_seen_d = rx_seen_q | (m_rx_done & ~rx_prev_q);
        if (tx_seen_d && rx_seen_d) begin
          cnt_d   = '0;
          state_d = ST_CAPTURE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_d.id   = RSP_ID_W'(grant_id_q);
          rsp_d.data = 8'h00;
          rsp_d.err  = 1'b1;
          state_d    = ST_RESP;
        end
      end
      ST_CAPTURE: begin
        if (cnt_q == CNT_W'(CAP_DLY - 1)) begin
          rsp_d.id   = RSP_ID_W'(grant_id_q);
          rsp_d.data = m_data_o;
          rsp_d.err  = 1'b0;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        // Lets the master release cs and park sclk before a mode change.
        if (cnt_q == CNT_W'(GAP_CYC - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      m_data_in_q <= '0;
      m_cpol_q    <= 1'b0;
      m_cpha_q    <= 1'b0;
      tx_prev_q   <= 1'b0;
      rx_prev_q   <= 1'b0;
      tx_seen_q   <= 1'b0;
      rx_seen_q   <= 1'b0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      m_data_in_q <= m_data_in_d;
      m_cpol_q    <= m_cpol_d;
      m_cpha_q    <= m_cpha_d;
      tx_prev_q   <= tx_prev_d;
      rx_prev_q   <= rx_prev_d;
      tx_seen_q   <= tx_seen_d;
      rx_seen_q   <= rx_seen_d;
      rsp_q       <= rsp_d;
    end
  end

  assign m_start   = (state_q == ST_XFER) || (state_q == ST_CAPTURE);
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_id    = ID_W'(rsp_q.id);
  assign rsp_data  = rsp_q.data;
  assign rsp_err   = rsp_q.err;
  assign grant_id  = grant_id_q;
  assign m_data_in = m_data_in_q;
  assign m_cpol    = m_cpol_q;
  assign m_cpha    = m_cpha_q;

endmodule

// File: doc/spi_xfer_arbiter.md
Name: spi_xfer_arbiter

Overview:
Shares one SPI byte master among NUM_REQ requesters using round-robin arbitration. Each request carries one byte plus its SPI mode (cpol/cpha). The block drives the master's start/mode/data inputs and detects completion from the master's tx_done/rx_done flags. It returns the received byte, or a timeout error, to the granted requester. It sits between the host-side request agents and the SPI master.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, requester id width; must satisfy ID_W >= clog2(NUM_REQ)
SETUP_CYC, 4, cycles data/mode are held stable before start asserts
CAP_DLY, 2, cycles after the done condition before m_data_o is sampled
GAP_CYC, 8, idle cycles with start low between transactions
TIMEOUT, 256, max cycles in XFER before abort

Ports:
clk  in  1  system clock
arst  in  1  reset; synchronous, active-high
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot accept pulse
req_data  in  NUM_REQ*8  tx byte; requester i at [8i+7:8i]
req_cpol  in  NUM_REQ  per-requester clock polarity
req_cpha  in  NUM_REQ  per-requester clock phase
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_id  out  ID_W  requester id of the response
rsp_data  out  8  received byte (0 on error)
rsp_err  out  1  1 = timeout
m_start  out  1  to master start
m_cpol  out  1  to master cpol
m_cpha  out  1  to master cpha
m_data_in  out  8  to master data_in
m_data_o  in  8  from master data_o
m_tx_done  in  1  from master
m_rx_done  in  1  from master
busy  out  1  1 in any state except IDLE
grant_id  out  ID_W  current/last granted id

Behaviour:
- One clock. Reset is synchronous and active-high. Inputs m_tx_done and m_rx_done are sampled on clk with no extra synchronizer, because the master runs on the same clk.
- Reset values: all outputs 0. rr_ptr=0. State is IDLE.
- States: IDLE, SETUP, XFER, CAPTURE, RESP, GAP.
- IDLE: if any req_valid, grant the first set bit searching from rr_ptr upward with wrap. In the same cycle:
  - pulse req_ready[g] for one cycle;
  - latch data, cpol and cpha into m_data_in/m_cpol/m_cpha;
  - set grant_id=g and rr_ptr=(g+1) mod NUM_REQ;
  - go to SETUP.
- Latched data/mode stay stable from the grant until the next grant.
- SETUP: count SETUP_CYC cycles with m_start=0, then go to XFER.
- XFER: m_start=1.
  - Track tx_seen and rx_seen, each set on the 0->1 edge of its flag.
  - When both are set, go to CAPTURE.
  - Edges of both flags in the same cycle count.
  - Timeout counter runs from XFER entry. At TIMEOUT cycles without completion: m_start=0, rsp_err=1, rsp_data=0, go to RESP.
- CAPTURE: m_start stays 1. Wait CAP_DLY cycles, sample m_data_o into rsp_data, set rsp_err=0, go to RESP.
- RESP: m_start=0. rsp_valid=1 and rsp_id/rsp_data/rsp_err are held until rsp_ready=1 while rsp_valid=1. Then drop rsp_valid and go to GAP.
- GAP: m_start=0 for GAP_CYC cycles, then go to IDLE. This guarantees the master's cs deasserts and sclk returns to idle before the next mode change.
- req_ready is asserted only in IDLE. Requests arriving in other states wait; there is no queueing.
- req_valid dropping before grant: no effect.
- Reset mid-transaction: immediate return to IDLE, m_start=0, no response issued.
- Counters saturate at their terminal value. They are sized clog2(max param)+1.

Decomposition:
- Package spi_arb_pkg holds:
  - state enum typedef (IDLE..GAP);
  - response struct {id, data, err};
  - default parameter constants.
- One sub-module, spi_rr_arbiter: combinational round-robin pick from req_valid and rr_ptr; outputs a one-hot grant and an index.
- Everything else is in the top-level FSM.

Test Plan:
- Single request, req0 data=0xA5, cpol=0, cpha=0, slave model returns 0x3C -> one req_ready[0] pulse; m_start high across the byte; rsp id=0, data=0x3C, err=0; m_start low for GAP_CYC=8 cycles.
- All four requesters valid continuously, with distinct data 0x11/0x22/0x33/0x44 -> grants in order 0,1,2,3,0; rsp_id matches the grant order; no requester is starved.
- req1 cpol=1, cpha=1, then req2 cpol=0, cpha=0 -> m_cpol/m_cpha stable from grant through RESP; mode changes only after GAP.
- Master flags held low (no done) -> after 256 XFER cycles: m_start drops; rsp err=1, data=0x00; next grant proceeds normally.
- rsp_ready held low for 20 cycles -> rsp_valid and its fields held constant; no new grant until acceptance.
- arst asserted for one cycle mid-XFER -> next cycle all outputs 0 and state IDLE; the pending requester is re-granted from rr_ptr=0 with no stale response.
